// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for an XNOR Fibonacci LFSR stream.
// Seeds from the stream, verifies LOCK_CNT predictions, then counts misses.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data carries one LFSR word this cycle
//   in_data    received word, MSB is LFSR bit N
//   clear      synchronous clear of err_count and stuck
//   locked     checker is in LOCKED
//   err_pulse  one-cycle pulse per mismatching beat while LOCKED
//   err_count  saturating mismatch count
//   stuck      sticky all-ones lockup flag
//
// Optional feature macro: LFSR_CHECK_STUCK_EN enables all-ones lockup
// detection; when undefined, stuck is tied low and all-ones is plain data.

module lfsr_checker #(
    parameter int NUM_BITS = 8,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [NUM_BITS-1:0] in_data,
    input  logic                clear,
    output logic                locked,
    output logic                err_pulse,
    output logic [ERR_W-1:0]    err_count,
    output logic                stuck
);

    generate
        if (NUM_BITS < 3 || NUM_BITS > 16) begin : g_bad_width
            $error("lfsr_checker: NUM_BITS must be 3..16");
        end
        if (LOCK_CNT < 1 || LOCK_CNT > 15) begin : g_bad_lock
            $error("lfsr_checker: LOCK_CNT must be 1..15");
        end
        if (LOSS_CNT < 1 || LOSS_CNT > 15) begin : g_bad_loss
            $error("lfsr_checker: LOSS_CNT must be 1..15");
        end
    endgenerate

    // Tap mask, bit k-1 set for LFSR tap k.
    function automatic logic [NUM_BITS-1:0] tap_mask(input int n);
        logic [15:0] m;
        case (n)
            3:       m = 16'h0006;
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m[NUM_BITS-1:0];
    endfunction

    localparam logic [NUM_BITS-1:0] TAPS = tap_mask(NUM_BITS);

    // One LFSR step: shift toward the MSB, feedback enters bit 1.
    // Feedback is the XNOR chain over the taps, highest tap first.
    function automatic logic [NUM_BITS-1:0] lfsr_next(
        input logic [NUM_BITS-1:0] w
    );
        logic fb;
        logic first;
        fb    = 1'b0;
        first = 1'b1;
        for (int i = NUM_BITS - 1; i >= 0; i--) begin
            if (TAPS[i]) begin
                if (first) begin
                    fb = w[i];
                end else begin
                    fb = fb ~^ w[i];
                end
                first = 1'b0;
            end
        end
        return {w[NUM_BITS-2:0], fb};
    endfunction

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_C  = 4'(LOSS_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    state_t              r_state;
    logic [NUM_BITS-1:0] r_pred;
    logic [3:0]          r_match_cnt;
    logic [3:0]          r_miss_cnt;
    logic [ERR_W-1:0]    r_err_count;
    logic                r_err_pulse;
    logic                r_locked;

    logic                w_match;
    logic [3:0]          w_match_inc;
    logic [3:0]          w_miss_inc;
    logic [NUM_BITS-1:0] w_pred_next;
    logic [NUM_BITS-1:0] w_data_next;

    assign w_match     = (in_data == r_pred);
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_miss_inc  = r_miss_cnt + 4'd1;
    assign w_pred_next = lfsr_next(r_pred);
    assign w_data_next = lfsr_next(in_data);

`ifdef LFSR_CHECK_STUCK_EN
    logic r_stuck;
    logic w_all_ones;
    assign w_all_ones = &in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HUNT;
            r_pred      <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_err_count <= '0;
            r_err_pulse <= 1'b0;
            r_locked    <= 1'b0;
`ifdef LFSR_CHECK_STUCK_EN
            r_stuck     <= 1'b0;
`endif
        end else begin
            r_err_pulse <= 1'b0;
            if (in_valid) begin
`ifdef LFSR_CHECK_STUCK_EN
                // All-ones is the XNOR lockup word: flag it and resync.
                if (w_all_ones) begin
                    r_stuck     <= 1'b1;
                    r_state     <= S_HUNT;
                    r_locked    <= 1'b0;
                    r_match_cnt <= '0;
                    r_miss_cnt  <= '0;
                end else
`endif
                begin
                    case (r_state)
                        S_HUNT: begin
                            r_pred      <= w_data_next;
                            r_match_cnt <= '0;
                            r_state     <= S_VERIFY;
                        end
                        S_VERIFY: begin
                            if (w_match) begin
                                r_pred      <= w_pred_next;
                                r_match_cnt <= w_match_inc;
                                if (w_match_inc == LOCK_C) begin
                                    r_state    <= S_LOCKED;
                                    r_locked   <= 1'b1;
                                    r_miss_cnt <= '0;
                                end
                            end else begin
                                r_pred      <= w_data_next;
                                r_match_cnt <= '0;
                            end
                        end
                        S_LOCKED: begin
                            // Flywheel: prediction never reseeds here.
                            r_pred <= w_pred_next;
                            if (w_match) begin
                                r_miss_cnt <= '0;
                            end else begin
                                r_err_pulse <= 1'b1;
                                if (r_err_count != ERR_MAX) begin
                                    r_err_count <= r_err_count + ERR_ONE;
                                end
                                r_miss_cnt <= w_miss_inc;
                                if (w_miss_inc == LOSS_C) begin
                                    r_state  <= S_HUNT;
                                    r_locked <= 1'b0;
                                end
                            end
                        end
                        default: begin
                            r_state  <= S_HUNT;
                            r_locked <= 1'b0;
                        end
                    endcase
                end
            end
            // Clear overrides any increment made this cycle.
            if (clear) begin
                r_err_count <= '0;
`ifdef LFSR_CHECK_STUCK_EN
                r_stuck     <= 1'b0;
`endif
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
`ifdef LFSR_CHECK_STUCK_EN
    assign stuck     = r_stuck;
`else
    assign stuck     = 1'b0;
`endif

endmodule
